// File: rtl/hdc_class_trainer_pkg.sv
// Shared definitions for the HDC class-hypervector trainer: sizes, class and
// element codes, FSM state encoding and the sign-to-element helper.
package hdc_class_trainer_pkg;

    localparam int DIM_DEF          = 10000;
    localparam int NUM_CLASS        = 2;
    localparam int BITS_PER_INT_DEF = 16;
    localparam int ADDR_W_DEF       = 14;
    localparam int HV_CNT_W         = 16;

    // Class codes match the classifier result encoding
    localparam logic CLASS_SPAM = 1'b0;
    localparam logic CLASS_HAM  = 1'b1;

    // Bipolar element codes; 2'b10 is not produced and reads as zero
    localparam logic [1:0] ELEM_ZERO = 2'b00;
    localparam logic [1:0] ELEM_POS  = 2'b01;
    localparam logic [1:0] ELEM_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FINAL = 2'd2
    } state_e;

    // Threshold result of an accumulator expressed as a bipolar element code
    function automatic logic [1:0] sign_code(input logic is_neg, input logic is_zero);
        if (is_zero)
            return ELEM_ZERO;
        else if (is_neg)
            return ELEM_NEG;
        else
            return ELEM_POS;
    endfunction

endpackage

// File: rtl/hdc_sat_acc.sv
// Signed saturating add of one bipolar element (+1/-1/0) to an accumulator.
module hdc_sat_acc
    import hdc_class_trainer_pkg::*;
#(
    parameter int BITS_PER_INT = BITS_PER_INT_DEF
) (
    input  logic signed [BITS_PER_INT-1:0] acc,
    input  logic        [1:0]              elem,
    output logic signed [BITS_PER_INT-1:0] sum
);

    localparam logic signed [BITS_PER_INT-1:0] MAX_V = {1'b0, {(BITS_PER_INT-1){1'b1}}};
    localparam logic signed [BITS_PER_INT-1:0] MIN_V = {1'b1, {(BITS_PER_INT-1){1'b0}}};
    localparam logic        [BITS_PER_INT-1:0] ONE   = BITS_PER_INT'(1);

    // Step by one toward the element's sign, holding at the range limits
    always_comb begin
        sum = acc;
        if (elem == ELEM_POS && acc != MAX_V)
            sum = acc + ONE;
        else if (elem == ELEM_NEG && acc != MIN_V)
            sum = acc - ONE;
    end

endmodule

// File: rtl/hdc_class_trainer.sv
// Trains Ham/Spam class hypervectors: accumulates labelled bipolar HV streams
// per class, thresholds the accumulators into class vectors on finalize, and
// serves the class vectors on a registered read port.
//
// Handshake: an element beat transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is high exactly while in ACCUM and does not
// depend on in_valid.
module hdc_class_trainer
    import hdc_class_trainer_pkg::*;
#(
    parameter int DIM          = DIM_DEF,
    parameter int BITS_PER_INT = BITS_PER_INT_DEF,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic        [1:0]              in_elem,
    input  logic                           in_label,
    input  logic                           in_last,
    input  logic                           finalize,
    output logic                           busy,
    output logic                           done,
    output logic                           err_len,
    output logic        [HV_CNT_W-1:0]     hv_count0,
    output logic        [HV_CNT_W-1:0]     hv_count1,
    input  logic                           rd_class,
    input  logic        [ADDR_W-1:0]       rd_addr,
    output logic signed [BITS_PER_INT-1:0] rd_data,
    output state_e                         state_dbg
);

    localparam int                 AW       = $clog2(DIM);
    localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(DIM - 1);
    localparam logic [ADDR_W-1:0]  IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]    CNT_LAST = (ADDR_W + 1)'(DIM - 1);
    localparam logic [ADDR_W:0]    CNT_DIM  = (ADDR_W + 1)'(DIM);
    localparam logic [ADDR_W:0]    CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [HV_CNT_W-1:0] HV_ONE  = HV_CNT_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q;      // CLEAR/FINAL address sweep; FINAL runs one extra drain cycle
    logic [ADDR_W-1:0] idx_q;      // element index of the HV being received
    logic              label_q;
    logic              fire, cur_label, hv_end, fin_ok;
    logic [AW-1:0]     raddr;

    // Accumulate pipeline: stage 1 reads the accumulator, stage 2 writes the sum back
    logic              p_valid_q, p_label_q;
    logic [AW-1:0]     p_addr_q;
    logic [1:0]        p_elem_q;
    logic              f_valid_q;
    logic [AW-1:0]     f_addr_q;

    logic signed [BITS_PER_INT-1:0] acc_mem [NUM_CLASS][DIM];
    logic        [1:0]              cls_mem [NUM_CLASS][DIM];
    logic signed [BITS_PER_INT-1:0] acc_rd0, acc_rd1, acc_cur, sat_sum;

    // Beat qualification and finalize acceptance
    always_comb begin
        in_ready  = (state_q == ST_ACCUM);
        busy      = (state_q != ST_ACCUM);
        state_dbg = state_q;
        fire      = in_valid && in_ready;
        cur_label = (idx_q == '0) ? in_label : label_q;
        hv_end    = fire && (idx_q == LAST_IDX);
        // A beat in the same cycle blocks finalize unless it closes the HV
        fin_ok    = finalize && (fire ? hv_end : (idx_q == '0));
        acc_cur   = p_label_q ? acc_rd1 : acc_rd0;
        // FINAL sweeps with the counter, ACCUM follows the element index
        raddr     = (state_q == ST_FINAL && cnt_q < CNT_DIM) ? cnt_q[AW-1:0] : idx_q[AW-1:0];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (cnt_q == CNT_LAST) state_d = ST_ACCUM;
            ST_ACCUM: if (fin_ok)            state_d = ST_FINAL;
            ST_FINAL: if (cnt_q == CNT_DIM)  state_d = ST_ACCUM;
            default:                         state_d = ST_CLEAR;
        endcase
    end

    // Control state, element index, counters and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            idx_q     <= '0;
            label_q   <= 1'b0;
            done      <= 1'b0;
            err_len   <= 1'b0;
            hv_count0 <= '0;
            hv_count1 <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == ST_FINAL) && (state_d == ST_ACCUM);
            if (state_d != state_q || state_q == ST_ACCUM)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CNT_ONE;
            if (fire) begin
                if (idx_q == '0)
                    label_q <= in_label;
                // A short HV restarts at element 0; its partial sum stays in the accumulator
                if (idx_q == LAST_IDX || in_last)
                    idx_q <= '0;
                else
                    idx_q <= idx_q + IDX_ONE;
                if (hv_end && cur_label == CLASS_HAM && hv_count1 != '1)
                    hv_count1 <= hv_count1 + HV_ONE;
                if (hv_end && cur_label == CLASS_SPAM && hv_count0 != '1)
                    hv_count0 <= hv_count0 + HV_ONE;
                if (hv_end != in_last)
                    err_len <= 1'b1;
            end
            if (state_q == ST_ACCUM && finalize && !fin_ok)
                err_len <= 1'b1;
        end
    end

    // Pipeline registers for accumulate write-back and class-vector write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_valid_q <= 1'b0;
            p_label_q <= 1'b0;
            p_addr_q  <= '0;
            p_elem_q  <= '0;
            f_valid_q <= 1'b0;
            f_addr_q  <= '0;
        end else begin
            p_valid_q <= fire;
            p_label_q <= cur_label;
            p_addr_q  <= idx_q[AW-1:0];
            p_elem_q  <= in_elem;
            f_valid_q <= (state_q == ST_FINAL) && (cnt_q < CNT_DIM);
            f_addr_q  <= cnt_q[AW-1:0];
        end
    end

    hdc_sat_acc #(.BITS_PER_INT(BITS_PER_INT)) u_sat (
        .acc  (acc_cur),
        .elem (p_elem_q),
        .sum  (sat_sum)
    );

    // Synchronous accumulator read, forwarding a same-address write-back
    always_ff @(posedge clk) begin
        acc_rd0 <= (p_valid_q && p_label_q == CLASS_SPAM && p_addr_q == raddr)
                   ? sat_sum : acc_mem[CLASS_SPAM][raddr];
        acc_rd1 <= (p_valid_q && p_label_q == CLASS_HAM && p_addr_q == raddr)
                   ? sat_sum : acc_mem[CLASS_HAM][raddr];
    end

    // Accumulator store: zeroed during CLEAR, otherwise one read-modify-write per cycle
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            acc_mem[CLASS_SPAM][cnt_q[AW-1:0]] <= '0;
            acc_mem[CLASS_HAM][cnt_q[AW-1:0]]  <= '0;
        end else if (p_valid_q) begin
            acc_mem[p_label_q][p_addr_q] <= sat_sum;
        end
    end

    // Class store: zeroed during CLEAR, thresholded for both classes during FINAL
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            cls_mem[CLASS_SPAM][cnt_q[AW-1:0]] <= ELEM_ZERO;
            cls_mem[CLASS_HAM][cnt_q[AW-1:0]]  <= ELEM_ZERO;
        end else if (f_valid_q) begin
            cls_mem[CLASS_SPAM][f_addr_q] <= sign_code(acc_rd0[BITS_PER_INT-1], acc_rd0 == '0);
            cls_mem[CLASS_HAM][f_addr_q]  <= sign_code(acc_rd1[BITS_PER_INT-1], acc_rd1 == '0);
        end
    end

    // Registered read port; element codes sign-extend directly to +1/-1/0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_data <= '0;
        else if ({1'b0, rd_addr} < CNT_DIM)
            rd_data <= {{(BITS_PER_INT-2){cls_mem[rd_class][rd_addr[AW-1:0]][1]}},
                        cls_mem[rd_class][rd_addr[AW-1:0]]};
        else
            rd_data <= '0;
    end

endmodule

// File: tb/tb_hdc_class_trainer.sv
// Directed bench for hdc_class_trainer with a small accumulator/threshold model
// and a read-port scoreboard queue.
module tb_hdc_class_trainer;
    import hdc_class_trainer_pkg::*;

    localparam int DIM = 8;
    localparam int BPI = 4;
    localparam int AW  = 14;
    localparam int SAT_MAX = (1 << (BPI - 1)) - 1;
    localparam int SAT_MIN = -(1 << (BPI - 1));

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, in_label = 1'b0, in_last = 1'b0, finalize = 1'b0, rd_class = 1'b0;
    logic [1:0] in_elem = '0;
    logic [AW-1:0] rd_addr = '0;
    logic in_ready, busy, done, err_len;
    logic [15:0] hv_count0, hv_count1;
    logic signed [BPI-1:0] rd_data;
    state_e state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_m [2][DIM];
    int cls_m [2][DIM];
    int cnt_m [2];
    logic [BPI-1:0] exp_q [$];

    // Clock
    always #5 clk = ~clk;

    hdc_class_trainer #(.DIM(DIM), .BITS_PER_INT(BPI), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_elem(in_elem), .in_label(in_label), .in_last(in_last), .finalize(finalize),
        .busy(busy), .done(done), .err_len(err_len), .hv_count0(hv_count0),
        .hv_count1(hv_count1), .rd_class(rd_class), .rd_addr(rd_addr), .rd_data(rd_data),
        .state_dbg(state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int elem_val(input logic [1:0] e);
        case (e)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    // Values 1/-1/0 map to element codes; 2 stands for the unused code 2'b10
    function automatic logic [2*DIM-1:0] pack_hv(input int v [DIM]);
        logic [2*DIM-1:0] r;
        r = '0;
        for (int i = 0; i < DIM; i++)
            r[2*i +: 2] = (v[i] == 1) ? 2'b01 : (v[i] == -1) ? 2'b11 : (v[i] == 2) ? 2'b10 : 2'b00;
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > SAT_MAX) ? SAT_MAX : (v < SAT_MIN) ? SAT_MIN : v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            cnt_m[c] = 0;
            for (int a = 0; a < DIM; a++) begin
                acc_m[c][a] = 0;
                cls_m[c][a] = 0;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err_len"}, err_len, 0);
        chk({tag, "_hv_count0"}, hv_count0, 0);
        chk({tag, "_hv_count1"}, hv_count1, 0);
        chk({tag, "_rd_data"}, {28'b0, rd_data}, 0);
        chk({tag, "_state"}, state_dbg, ST_CLEAR);
    endtask

    task automatic wait_clear(input string tag);
        int cyc = 0;
        while (busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_clear_cycles"}, cyc, DIM);
        chk({tag, "_ready_after_clear"}, in_ready, 1);
        model_clear();
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; finalize = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values(tag);
        reset = 1'b1;
        wait_clear(tag);
    endtask

    // Drive n_beats elements of one HV; in_last marks the final beat driven
    task automatic send_hv(input logic lbl, input logic [2*DIM-1:0] elems, input int n_beats);
        for (int i = 0; i < n_beats; i++) begin
            @(negedge clk);
            if (i == 0) chk("in_ready_beat0", in_ready, 1);
            in_valid = 1'b1;
            in_label = lbl;
            in_elem  = elems[2*i +: 2];
            in_last  = (i == n_beats - 1);
            acc_m[lbl][i] = sat(acc_m[lbl][i] + elem_val(elems[2*i +: 2]));
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (n_beats == DIM && cnt_m[lbl] < 65535) cnt_m[lbl]++;
    endtask

    task automatic do_finalize(input string tag);
        int cyc = 0;
        @(negedge clk); finalize = 1'b1;
        @(negedge clk); finalize = 1'b0;
        chk({tag, "_busy_final"}, busy, 1);
        chk({tag, "_ready_final"}, in_ready, 0);
        while (done !== 1'b1 && cyc < 4 * DIM) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, done, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < DIM; a++)
                cls_m[c][a] = (acc_m[c][a] > 0) ? 1 : (acc_m[c][a] < 0) ? -1 : 0;
    endtask

    task automatic read_at(input string tag, input int c, input logic [AW-1:0] addr, input int exp_v);
        exp_q.push_back(BPI'(exp_v));
        @(negedge clk);
        rd_class = c[0];
        rd_addr  = addr;
        @(posedge clk);
        #1;
        chk($sformatf("%s_c%0d_a%0d", tag, c, addr), {28'b0, rd_data}, {28'b0, exp_q.pop_front()});
    endtask

    task automatic read_class(input string tag, input int c);
        for (int a = 0; a < DIM; a++)
            read_at(tag, c, AW'(a), cls_m[c][a]);
    endtask

    initial begin
        int hv_a [DIM];
        int hv_b [DIM];
        int all_pos [DIM];
        int all_neg [DIM];
        for (int i = 0; i < DIM; i++) begin
            all_pos[i] = 1;
            all_neg[i] = -1;
        end
        hv_a = '{1, -1, 1, -1, 0, 0, 1, -1};
        hv_b = '{1, 1, -1, -1, 2, 1, 0, -1};

        // 1: reset and clear
        apply_reset("rst1");
        read_class("clr0", 0);
        read_class("clr1", 1);

        // 2: three ham HVs of all +1
        repeat (3) send_hv(CLASS_HAM, pack_hv(all_pos), DIM);
        chk("t2_err_len", err_len, 0);
        do_finalize("t2");
        read_class("t2", 1);
        read_class("t2", 0);
        chk("t2_hv_count1", hv_count1, cnt_m[1]);
        chk("t2_hv_count0", hv_count0, cnt_m[0]);

        // 3: mixed ham HVs from a fresh state
        apply_reset("rst3");
        send_hv(CLASS_HAM, pack_hv(hv_a), DIM);
        send_hv(CLASS_HAM, pack_hv(hv_b), DIM);
        do_finalize("t3");
        read_class("t3", 1);

        // 4: spam saturation at the negative limit, then recovery back to zero
        repeat (10) send_hv(CLASS_SPAM, pack_hv(all_neg), DIM);
        do_finalize("t4a");
        read_class("t4a", 0);
        chk("t4_hv_count0", hv_count0, cnt_m[0]);
        repeat (8) send_hv(CLASS_SPAM, pack_hv(all_pos), DIM);
        do_finalize("t4b");
        read_class("t4b", 0);
        read_class("t4b", 1);
        read_at("oob", 1, AW'(DIM), 0);
        read_at("oob", 1, '1, 0);

        // 5: in_last on element 5, then a complete HV restarting at element 0
        chk("t5_err_before", err_len, 0);
        send_hv(CLASS_HAM, pack_hv(all_neg), 6);
        chk("t5_err_len", err_len, 1);
        chk("t5_hv_count1", hv_count1, cnt_m[1]);
        send_hv(CLASS_SPAM, pack_hv(all_pos), DIM);
        chk("t5_hv_count0", hv_count0, cnt_m[0]);
        chk("t5_hv_count1_after", hv_count1, cnt_m[1]);
        do_finalize("t5");
        read_class("t5", 1);
        read_class("t5", 0);

        // 6: reset in the middle of FINAL
        @(negedge clk); finalize = 1'b1;
        @(negedge clk); finalize = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_busy_mid", busy, 1);
        reset = 1'b0;
        #1;
        check_reset_values("t6_async");
        @(negedge clk);
        reset = 1'b1;
        wait_clear("t6");
        read_class("t6", 0);
        read_class("t6", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
